// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv32i_pkg -- shared loader state encoding and frame constants
// Rev    : 1.0
// ============================================================================
package rv32i_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4
  } loader_state_e;

  localparam int C_LEN_FIELD_BYTES = 2;
  localparam int C_CHK_WIDTH       = 8;
  localparam int C_LEN_WIDTH       = C_LEN_FIELD_BYTES * 8;

  // Modulo-256 running sum of payload bytes.
  function automatic logic [C_CHK_WIDTH-1:0] chk_add(
    input logic [C_CHK_WIDTH-1:0] acc,
    input logic [7:0]             data
  );
    return acc + data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/loader_rx_frame.sv
`default_nettype none
// ============================================================================
// Module : loader_rx_frame -- frame parser FSM with length/index/checksum state
// Rev    : 1.0
// ============================================================================
module loader_rx_frame
  import rv32i_pkg::*;
#(
  parameter int MEMORY_SIZE = 1024,
  parameter int IDX_W       = $clog2(MEMORY_SIZE) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  output logic             busy_o,
  output logic             start_ack_o,
  output logic             wr_req_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [7:0]       wr_data_o,
  output logic             done_o,
  output logic             error_o
);

  localparam logic [C_LEN_WIDTH-1:0] C_MAX_LEN = C_LEN_WIDTH'(MEMORY_SIZE);

  loader_state_e              state_q, state_d;
  logic [C_LEN_WIDTH-1:0]     len_q, len_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [C_CHK_WIDTH-1:0]     acc_q, acc_d;
  logic                       hs;
  logic [C_LEN_WIDTH-1:0]     len_full;
  logic [C_LEN_WIDTH-1:0]     idx_next_ext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Ready is a pure function of the registered state, so it never glitches.
  assign rx_ready_o   = (state_q != ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign hs           = rx_valid_i & rx_ready_o;
  assign len_full     = {rx_data_i, len_q[7:0]};
  assign idx_next_ext = {{(C_LEN_WIDTH-IDX_W){1'b0}}, idx_q} + C_LEN_WIDTH'(1);
  assign wr_idx_o     = idx_q;
  assign wr_data_o    = rx_data_i;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    start_ack_o = 1'b0;
    wr_req_o    = 1'b0;
    done_o      = 1'b0;
    error_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          start_ack_o = 1'b1;
          len_d       = '0;
          idx_d       = '0;
          acc_d       = '0;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (hs) begin
          len_d[7:0] = rx_data_i;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (hs) begin
          len_d = len_full;
          if (len_full > C_MAX_LEN) begin
            error_o = 1'b1;
            state_d = ST_IDLE;
          end else if (len_full == '0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          wr_req_o = 1'b1;
          acc_d    = chk_add(acc_q, rx_data_i);
          idx_d    = idx_q + IDX_W'(1);
          if (idx_next_ext == len_q) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (hs) begin
          if (rx_data_i == acc_q) begin
            done_o = 1'b1;
          end else begin
            error_o = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_loader -- byte-stream boot loader driving the imem write port
// Rev    : 1.0
// ============================================================================
module imem_loader
  import rv32i_pkg::*;
#(
  parameter int MEMORY_SIZE = 1024,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [7:0]            Rx_Data,
  input  logic                  Rx_Valid,
  output logic                  Rx_Ready,
  output logic                  WR_En,
  output logic [ADDR_WIDTH-1:0] WR_Addr,
  output logic [7:0]            WR_Data,
  output logic                  CPU_Hold,
  output logic                  Done,
  output logic                  Error
);

  localparam int C_IDX_W = $clog2(MEMORY_SIZE) + 1;

  logic               start_ack;
  logic               busy;
  logic               wr_req;
  logic [C_IDX_W-1:0] wr_idx;
  logic [7:0]         wr_byte;
  logic               done_evt;
  logic               error_evt;

  logic               wr_en_q;
  logic [C_IDX_W-1:0] wr_addr_q;
  logic [7:0]         wr_data_q;
  logic               done_q;
  logic               error_q;

  loader_rx_frame #(
    .MEMORY_SIZE (MEMORY_SIZE),
    .IDX_W       (C_IDX_W)
  ) u_rx_frame (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .start_i     (Start),
    .rx_data_i   (Rx_Data),
    .rx_valid_i  (Rx_Valid),
    .rx_ready_o  (Rx_Ready),
    .busy_o      (busy),
    .start_ack_o (start_ack),
    .wr_req_o    (wr_req),
    .wr_idx_o    (wr_idx),
    .wr_data_o   (wr_byte),
    .done_o      (done_evt),
    .error_o     (error_evt)
  );

  // The write lands one cycle after its handshake; the final write therefore
  // overlaps the checksum acceptance cycle while CPU_Hold is still high.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_en_q <= wr_req;
      if (wr_req) begin
        wr_addr_q <= wr_idx;
        wr_data_q <= wr_byte;
      end
      done_q <= done_evt;
      if (start_ack) begin
        error_q <= 1'b0;
      end else if (error_evt) begin
        error_q <= 1'b1;
      end
    end
  end

  assign WR_En    = wr_en_q;
  assign WR_Addr  = {{(ADDR_WIDTH-C_IDX_W){1'b0}}, wr_addr_q};
  assign WR_Data  = wr_data_q;
  assign CPU_Hold = busy;
  assign Done     = done_q;
  assign Error    = error_q;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Byte-stream boot loader that writes a program image into the instruction memory's byte write port while the RV32I core is held in reset. It receives a length-prefixed, checksummed frame over a valid/ready byte interface (fed by a UART receiver or testbench) and writes one byte per accepted payload byte at sequential byte addresses from 0. It is the write-side counterpart of the core's combinational instruction fetch path.

## Interface
- MEMORY_SIZE, 1024, instruction memory capacity in bytes; frames longer than this are rejected.
- ADDR_WIDTH, 32, width of WR_Addr.
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request to begin a load session; ignored unless IDLE.
- Rx_Data  input  8  incoming frame byte.
- Rx_Valid  input  1  Rx_Data is valid.
- Rx_Ready  output  1  loader can accept a byte; handshake completes when Rx_Valid & Rx_Ready at a rising edge.
- WR_En  output  1  byte write strobe to instruction memory.
- WR_Addr  output  ADDR_WIDTH  byte address of the write.
- WR_Data  output  8  byte to write.
- CPU_Hold  output  1  holds the core in reset while a session is active.
- Done  output  1  one-cycle pulse on successful load.
- Error  output  1  sticky failure flag, cleared by the next accepted Start.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit byte count N, little-endian), N payload bytes, then one CHK byte equal to the 8-bit modulo-256 sum of the payload bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK.
- IDLE: Rx_Ready=0 and CPU_Hold=0. On Start: clear Error, byte index and checksum accumulator; go to LEN_LO; set CPU_Hold=1.
- LEN_LO / LEN_HI: Rx_Ready=1. Each handshake captures one length byte.
- After LEN_HI, the next state depends on N:
  - N > MEMORY_SIZE: set Error and go to IDLE. No writes occur.
  - N = 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA: Rx_Ready=1. Each handshake adds the byte to the checksum, schedules a write at the current index, and increments the index. After byte N-1, go to CHECK.
- CHECK: Rx_Ready=1. On handshake:
  - If the byte equals the accumulator, pulse Done.
  - Otherwise set Error.
  - In both cases go to IDLE.
- Writes are never rolled back. On a checksum failure the memory holds the received bytes.
- Start outside IDLE is ignored.
- Rx_Valid without Rx_Ready has no effect. The upstream source must hold Rx_Data stable until the handshake.

## Timing
- Reset values: Rx_Ready=0, WR_En=0, WR_Addr=0, WR_Data=0, CPU_Hold=0, Done=0, Error=0, state=IDLE, index=0, accumulator=0.
- Reset is asynchronous. Asserting it mid-session forces all outputs to their reset values immediately and abandons the frame.
- Start sampled at edge t: Rx_Ready=1 and CPU_Hold=1 from t+1.
- Data handshake at edge t: WR_En=1, WR_Addr=k and WR_Data=byte during cycle t+1 (registered). WR_En is otherwise 0.
- Sustained throughput is one byte per cycle. Backpressure is purely upstream: Rx_Ready never deasserts in DATA.
- CHK handshake at edge t: in cycle t+1, state=IDLE, Rx_Ready=0, CPU_Hold=0, and either Done=1 or Error=1.
- CHK can arrive at the earliest one edge after the last data handshake, so the final WR_En pulse coincides with the CHK acceptance cycle, before CPU_Hold drops.
- Oversize N, with LEN_HI accepted at edge t: Error=1, CPU_Hold=0 and Rx_Ready=0 from t+1.
- Arithmetic widths:
  - Index is clog2(MEMORY_SIZE)+1 bits, zero-extended onto WR_Addr.
  - Accumulator is 8 bits and wraps modulo 256.
  - N is 16 bits and is compared unsigned.

## Structure
- Shared package rv32i_pkg:
  - loader state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK)
  - frame constants: length field bytes = 2, checksum width = 8
- One natural sub-module, loader_rx_frame: the FSM plus length/index/checksum counters, producing a registered write request.
- The top imem_loader registers the write port and drives CPU_Hold, Done and Error.

## Test plan
- Nominal load: Start; frame 04 00 93 00 80 3E 51, sent back-to-back.
  - Writes (0,93) (1,00) (2,80) (3,3E) on consecutive cycles.
  - Done pulses once; Error=0.
  - CPU_Hold is high from the cycle after Start until the cycle Done is asserted.
- Bad checksum: the same frame with CHK=52.
  - The same four writes occur.
  - Error=1 and stays high; Done never pulses.
  - The next Start clears Error.
- Oversize length with MEMORY_SIZE=1024: frame 01 04.
  - Error=1 the cycle after LEN_HI; no WR_En pulses; Rx_Ready=0.
- Gapped input: the nominal frame with Rx_Valid high only every third cycle.
  - Identical writes and Done; each WR_En comes exactly one cycle after its handshake.
- Reset mid-DATA: assert Reset after 2 payload bytes are accepted.
  - All outputs drop to 0 asynchronously.
  - A subsequent Start plus the full nominal frame loads correctly.
- Empty frame and Start while busy: frame 00 00 00 gives Done with no writes. A Start pulsed during LEN_HI of a nominal frame has no effect.
